serial_transmit_fifo: RTL and testbench

//   Parametrised result transmitter: queues found nonces/result words from the hash core in a FIFO
//   and serialises each one MSB-byte-first into the byte-level UART transmitter. An optional

---
 rtl/serial_transmit_fifo_if.sv | 28 ++
 rtl/serial_transmit_fifo.sv | 172 +++++++++++++++++
 tb/tb_serial_transmit_fifo.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_transmit_fifo_if.sv
// Handshake bundle for serial_transmit_fifo: the result push side, the FIFO
// status flags and the byte-level UART handshake.
interface serial_transmit_fifo_if #(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 3
);
    logic                    push;
    logic [8*WORD_BYTES-1:0] word;
    logic                    full;
    logic [ADDR_W:0]         count;
    logic                    overflow;
    logic                    busy;
    logic                    tx_ready;
    logic                    tx_start;
    logic [7:0]              tx_byte;

    // Environment side: result source plus the UART transmitter.
    modport master (
        output push, word, tx_ready,
        input  full, count, overflow, busy, tx_start, tx_byte
    );

    // Transmitter side: the FIFO and byte serializer.
    modport slave (
        input  push, word, tx_ready,
        output full, count, overflow, busy, tx_start, tx_byte
    );
endinterface

// File: rtl/serial_transmit_fifo.sv
// Result transmitter: queues result words in a FIFO and serialises each one
// MSB byte first into a byte-wide UART transmitter, optionally followed by a
// terminator byte. Pushes into a full FIFO are dropped and flagged sticky.
module serial_transmit_fifo #(
    parameter int         WORD_BYTES      = 4,
    parameter int         FIFO_DEPTH      = 8,
    parameter int         ADDR_W          = 3,
    parameter int         SEND_TERMINATOR = 1,
    parameter logic [7:0] TERMINATOR      = 8'h0A
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_transmit_fifo_if.slave bus
);
    localparam int                W        = 8 * WORD_BYTES;
    localparam int                IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, START, HOLD, WAIT} state_t;

    state_t            state;
    state_t            state_next;

    logic [W-1:0]      mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              full;
    logic              overflow;

    logic              do_push;
    logic              pop;
    logic              shift;
    logic              load_term;

    logic [W-1:0]      head;
    logic [W-1:0]      sh;
    logic [W-1:0]      sh_shl;
    logic [IDX_W-1:0]  idx;
    logic              term_sent;
    logic [7:0]        tx_byte;

    // full is a register, so a push while full is dropped even if the
    // serializer pops in the same cycle.
    assign do_push = bus.push && !full;
    assign head    = mem[rd_ptr];
    assign sh_shl  = sh << 8;

    // Occupancy after this cycle's accepted push and pop.
    always_comb begin
        count_next = count;
        if (do_push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !do_push) begin
            count_next = count - CNT_ONE;
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            full  <= (count_next == DEPTH);
            if (bus.push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.word;
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Serializer next state; HOLD skips tx_ready for one cycle so a UART
    // whose ready flag lags the strobe is not mistaken for ready.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shift      = 1'b0;
        load_term  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && bus.tx_ready) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: state_next = HOLD;
            HOLD:  state_next = WAIT;
            WAIT: begin
                if (bus.tx_ready) begin
                    if (idx != LAST_IDX) begin
                        shift      = 1'b1;
                        state_next = START;
                    end else if (SEND_TERMINATOR != 0 && !term_sent) begin
                        load_term  = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register holding the word being sent, top byte next out.
    always_ff @(posedge clk) begin
        if (pop) begin
            sh <= head;
        end else if (shift) begin
            sh <= sh_shl;
        end
    end

    // Byte index, terminator flag and the held output byte; tx_byte is
    // loaded on entry to START so it is stable during the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            term_sent <= 1'b0;
            tx_byte   <= 8'h00;
        end else if (pop) begin
            idx       <= '0;
            term_sent <= 1'b0;
            tx_byte   <= head[W-1 -: 8];
        end else if (shift) begin
            idx     <= idx + IDX_ONE;
            tx_byte <= sh_shl[W-1 -: 8];
        end else if (load_term) begin
            term_sent <= 1'b1;
            tx_byte   <= TERMINATOR;
        end
    end

    assign bus.full     = full;
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.busy     = (state != IDLE);
    assign bus.tx_start = (state == START);
    assign bus.tx_byte  = tx_byte;

endmodule

// File: tb/tb_serial_transmit_fifo.sv
// Self-checking bench for serial_transmit_fifo: a 4-byte/terminator instance
// and a 2-byte/raw instance, each driven by a model UART with random busy time.
// Expected byte streams come from the pushed words, split MSB first.
module tb_serial_transmit_fifo;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    serial_transmit_fifo_if #(.WORD_BYTES(4), .ADDR_W(3)) bus_a ();
    serial_transmit_fifo_if #(.WORD_BYTES(2), .ADDR_W(3)) bus_b ();

    serial_transmit_fifo #(
        .WORD_BYTES(4), .FIFO_DEPTH(8), .ADDR_W(3),
        .SEND_TERMINATOR(1), .TERMINATOR(8'h0A)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    serial_transmit_fifo #(
        .WORD_BYTES(2), .FIFO_DEPTH(8), .ADDR_W(3),
        .SEND_TERMINATOR(0), .TERMINATOR(8'h0A)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int tests = 0;
    int fails = 0;

    logic uart_en_a = 1'b0;
    logic uart_en_b = 1'b0;
    int   ucnt_a    = 0;
    int   ucnt_b    = 0;
    int   dbl_a     = 0;
    logic prev_a    = 1'b0;

    byte unsigned got_a[$];
    byte unsigned got_b[$];
    byte unsigned exp_a[$];
    byte unsigned exp_b[$];

    // Model UART ready: drops for a random time after each accepted byte.
    assign bus_a.tx_ready = uart_en_a && (ucnt_a == 0);
    assign bus_b.tx_ready = uart_en_b && (ucnt_b == 0);

    // Model UART for instance A: capture strobed bytes, track strobe width.
    always @(negedge clk) begin
        if (bus_a.tx_start) begin
            got_a.push_back(bus_a.tx_byte);
            ucnt_a <= $urandom_range(1, 6);
        end else if (ucnt_a > 0) begin
            ucnt_a <= ucnt_a - 1;
        end
        if (bus_a.tx_start && prev_a) begin
            dbl_a <= dbl_a + 1;
        end
        prev_a <= bus_a.tx_start;
    end

    // Model UART for instance B.
    always @(negedge clk) begin
        if (bus_b.tx_start) begin
            got_b.push_back(bus_b.tx_byte);
            ucnt_b <= $urandom_range(1, 6);
        end else if (ucnt_b > 0) begin
            ucnt_b <= ucnt_b - 1;
        end
    end

    // Index of the first difference between two byte streams, -1 if equal.
    function automatic int first_diff(input byte unsigned g[$], input byte unsigned e[$]);
        if (g.size() != e.size()) return (g.size() < e.size()) ? g.size() : e.size();
        foreach (e[i]) if (g[i] != e[i]) return i;
        return -1;
    endfunction

    task automatic add_exp_a(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_a.push_back(w[8*i +: 8]);
        exp_a.push_back(8'h0A);
    endtask

    task automatic add_exp_b(input logic [15:0] w);
        for (int i = 1; i >= 0; i--) exp_b.push_back(w[8*i +: 8]);
    endtask

    // Drive one push cycle; called just after a falling edge.
    task automatic push_a(input logic [31:0] w, input bit accepted);
        bus_a.push = 1'b1;
        bus_a.word = w;
        @(negedge clk);
        bus_a.push = 1'b0;
        if (accepted) add_exp_a(w);
    endtask

    task automatic push_b(input logic [15:0] w);
        bus_b.push = 1'b1;
        bus_b.word = w;
        @(negedge clk);
        bus_b.push = 1'b0;
        add_exp_b(w);
    endtask

    task automatic wait_idle_a(output bit timed_out);
        int stable = 0;
        for (int i = 0; i < 3000 && stable < 3; i++) begin
            @(negedge clk);
            if (!bus_a.busy && bus_a.count == 0 && ucnt_a == 0) stable++;
            else stable = 0;
        end
        timed_out = (stable < 3);
    endtask

    task automatic wait_idle_b(output bit timed_out);
        int stable = 0;
        for (int i = 0; i < 3000 && stable < 3; i++) begin
            @(negedge clk);
            if (!bus_b.busy && bus_b.count == 0 && ucnt_b == 0) stable++;
            else stable = 0;
        end
        timed_out = (stable < 3);
    endtask

    task automatic clear_streams();
        got_a.delete(); exp_a.delete();
        got_b.delete(); exp_b.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        bus_a.push = 1'b0;
        bus_b.push = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_streams();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({bus_a.full, bus_a.count, bus_a.overflow, bus_a.busy, bus_a.tx_start, bus_a.tx_byte} !== '0)
            $display("FAIL reset_a: full=%b count=%0d ovf=%b busy=%b start=%b byte=%h, want all 0",
                     bus_a.full, bus_a.count, bus_a.overflow, bus_a.busy, bus_a.tx_start, bus_a.tx_byte);
        if ({bus_a.full, bus_a.count, bus_a.overflow, bus_a.busy, bus_a.tx_start, bus_a.tx_byte} !== '0) fails++;
        tests++;
        if ({bus_b.full, bus_b.count, bus_b.overflow, bus_b.busy, bus_b.tx_start, bus_b.tx_byte} !== '0) begin
            fails++;
            $display("FAIL reset_b: full=%b count=%0d ovf=%b busy=%b start=%b byte=%h, want all 0",
                     bus_b.full, bus_b.count, bus_b.overflow, bus_b.busy, bus_b.tx_start, bus_b.tx_byte);
        end
    endtask

    task automatic test_single();
        int lat;
        bit to;
        int pos;
        uart_en_a = 1'b1;
        bus_a.push = 1'b1;
        bus_a.word = 32'hDEADBEEF;
        add_exp_a(32'hDEADBEEF);
        @(negedge clk);
        bus_a.push = 1'b0;
        lat = 1;
        while (!bus_a.tx_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL single_latency: first tx_start %0d cycles after push, want 2", lat);
        end
        tests++;
        if (bus_a.tx_byte !== 8'hDE) begin
            fails++;
            $display("FAIL single_first_byte: got %h, want de", bus_a.tx_byte);
        end
        wait_idle_a(to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL single_idle: busy=%b count=%0d after timeout, want idle", bus_a.busy, bus_a.count);
        end
        tests++;
        pos = first_diff(got_a, exp_a);
        if (pos !== -1) begin
            fails++;
            $display("FAIL single_stream: differs at byte %0d, got %0d bytes, want %0d bytes",
                     pos, got_a.size(), exp_a.size());
        end
        tests++;
        if (bus_a.tx_byte !== 8'h0A) begin
            fails++;
            $display("FAIL single_hold_byte: tx_byte %h after frame, want 0a", bus_a.tx_byte);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        bit rose = 1'b0;
        int prev;
        int pos;
        int n;
        clear_streams();
        uart_en_a = 1'b1;
        push_a($urandom, 1'b1);
        n = 0;
        while (!bus_a.tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) push_a($urandom, 1'b1);
        tests++;
        if (bus_a.count !== 4'd3) begin
            fails++;
            $display("FAIL queue_count3: count=%0d, want 3", bus_a.count);
        end
        prev = 3;
        n = 0;
        while (bus_a.count != 0 && n < 3000) begin
            @(negedge clk);
            if (int'(bus_a.count) > prev) rose = 1'b1;
            prev = int'(bus_a.count);
            n++;
        end
        tests++;
        if (rose || bus_a.count !== 4'd0) begin
            fails++;
            $display("FAIL queue_drain: count=%0d rose=%b, want steady drain to 0", bus_a.count, rose);
        end
        wait_idle_a(to);
        tests++;
        pos = first_diff(got_a, exp_a);
        if (to || pos !== -1) begin
            fails++;
            $display("FAIL queue_stream: timeout=%b diff at %0d, got %0d bytes, want %0d bytes",
                     to, pos, got_a.size(), exp_a.size());
        end
        tests++;
        if (dbl_a !== 0) begin
            fails++;
            $display("FAIL strobe_width: %0d multi-cycle tx_start pulses, want 0", dbl_a);
        end
    endtask

    task automatic test_overflow();
        bit to;
        int pos;
        clear_streams();
        uart_en_a = 1'b0;
        for (int i = 0; i < 8; i++) push_a($urandom, 1'b1);
        tests++;
        if ({bus_a.full, bus_a.count, bus_a.overflow} !== {1'b1, 4'd8, 1'b0}) begin
            fails++;
            $display("FAIL fill8: full=%b count=%0d ovf=%b, want 1 8 0", bus_a.full, bus_a.count, bus_a.overflow);
        end
        push_a($urandom, 1'b0);
        tests++;
        if ({bus_a.full, bus_a.count, bus_a.overflow} !== {1'b1, 4'd8, 1'b1}) begin
            fails++;
            $display("FAIL push9: full=%b count=%0d ovf=%b, want 1 8 1", bus_a.full, bus_a.count, bus_a.overflow);
        end
        uart_en_a = 1'b1;
        wait_idle_a(to);
        tests++;
        pos = first_diff(got_a, exp_a);
        if (to || pos !== -1) begin
            fails++;
            $display("FAIL overflow_stream: timeout=%b diff at %0d, got %0d bytes, want %0d bytes",
                     to, pos, got_a.size(), exp_a.size());
        end
    endtask

    task automatic test_push_pop_full();
        bit to;
        int pos;
        do_reset();
        uart_en_a = 1'b0;
        for (int i = 0; i < 8; i++) push_a($urandom, 1'b1);
        uart_en_a = 1'b1;
        push_a($urandom, 1'b0);
        tests++;
        if ({bus_a.full, bus_a.count, bus_a.overflow} !== {1'b0, 4'd7, 1'b1}) begin
            fails++;
            $display("FAIL push_pop_full: full=%b count=%0d ovf=%b, want 0 7 1",
                     bus_a.full, bus_a.count, bus_a.overflow);
        end
        wait_idle_a(to);
        tests++;
        pos = first_diff(got_a, exp_a);
        if (to || pos !== -1) begin
            fails++;
            $display("FAIL push_pop_stream: timeout=%b diff at %0d, got %0d bytes, want %0d bytes",
                     to, pos, got_a.size(), exp_a.size());
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        int pos;
        int seen = 0;
        int late = 0;
        int n = 0;
        uart_en_a = 1'b0;
        for (int i = 0; i < 3; i++) push_a($urandom, 1'b1);
        uart_en_a = 1'b1;
        while (seen < 2 && n < 200) begin
            @(negedge clk);
            if (bus_a.tx_start) seen++;
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({bus_a.count, bus_a.busy, bus_a.overflow, bus_a.full, bus_a.tx_start, bus_a.tx_byte} !== '0 || seen != 2) begin
            fails++;
            $display("FAIL midframe_reset: count=%0d busy=%b ovf=%b full=%b start=%b strobes=%0d, want zeros after 2 strobes",
                     bus_a.count, bus_a.busy, bus_a.overflow, bus_a.full, bus_a.tx_start, seen);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.tx_start) late++;
        end
        tests++;
        if (late !== 0) begin
            fails++;
            $display("FAIL midframe_silence: %0d tx_start after reset, want 0", late);
        end
        clear_streams();
        push_a($urandom, 1'b1);
        wait_idle_a(to);
        tests++;
        pos = first_diff(got_a, exp_a);
        if (to || pos !== -1) begin
            fails++;
            $display("FAIL midframe_fresh: timeout=%b diff at %0d, got %0d bytes, want %0d bytes",
                     to, pos, got_a.size(), exp_a.size());
        end
    endtask

    task automatic test_narrow_wrap();
        bit to;
        int pos;
        int n;
        clear_streams();
        uart_en_b = 1'b1;
        push_b(16'h1234);
        wait_idle_b(to);
        tests++;
        pos = first_diff(got_b, exp_b);
        if (to || pos !== -1 || got_b.size() != 2) begin
            fails++;
            $display("FAIL narrow_word: timeout=%b diff at %0d, got %0d bytes, want 2 bytes 12 34",
                     to, pos, got_b.size());
        end
        tests++;
        if (bus_b.tx_byte !== 8'h34) begin
            fails++;
            $display("FAIL narrow_hold_byte: tx_byte %h, want 34", bus_b.tx_byte);
        end
        clear_streams();
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (bus_b.full && n < 500) begin
                @(negedge clk);
                n++;
            end
            push_b(16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle_b(to);
        tests++;
        pos = first_diff(got_b, exp_b);
        if (to || pos !== -1) begin
            fails++;
            $display("FAIL wrap_stream: timeout=%b diff at %0d, got %0d bytes, want %0d bytes",
                     to, pos, got_b.size(), exp_b.size());
        end
        tests++;
        if (bus_b.overflow !== 1'b0) begin
            fails++;
            $display("FAIL wrap_overflow: overflow=%b, want 0", bus_b.overflow);
        end
    endtask

    initial begin
        bus_a.push = 1'b0;
        bus_a.word = '0;
        bus_b.push = 1'b0;
        bus_b.word = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_reset_midframe();
        test_narrow_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
